// File: rtl/usi_pkg.sv
// Shared USI bus constants, block address map and master-arbiter state encoding.
package usi_pkg;

  localparam int USI_DATA_BIT    = 32;
  localparam int USI_ADRS_MSB    = 15;
  localparam int USI_MAX_MASTERS = 8;

  // Block select codes carried in the upper address byte
  localparam logic [7:0] BLK_GPIO  = 8'h01;
  localparam logic [7:0] BLK_UART  = 8'h02;
  localparam logic [7:0] BLK_SPI   = 8'h03;
  localparam logic [7:0] BLK_I2C   = 8'h04;
  localparam logic [7:0] BLK_TIMER = 8'h05;
  localparam logic [7:0] BLK_MCB   = 8'h06;
  localparam logic [7:0] BLK_VDMA  = 8'h07;
  localparam logic [7:0] BLK_ADMA  = 8'h08;
  localparam logic [7:0] BLK_PSRAM = 8'h09;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } usiState_e;

  function automatic logic [2:0] oneHotIdx(input logic [USI_MAX_MASTERS-1:0] oneHot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < USI_MAX_MASTERS; i++) begin
      if (oneHot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/usi_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester after ptr_i.
module usi_rr_picker #(
  parameter int pNum = 4
) (
  input  logic [pNum-1:0]         reqVec_i,
  input  logic [$clog2(pNum)-1:0] ptr_i,
  output logic [pNum-1:0]         gnt_o,
  output logic                    valid_o
);

  localparam int PtrBit = $clog2(pNum);

  logic [PtrBit-1:0] idx;
  logic              found;

  // The last owner sits at ptr_i, so it is scanned last and gets lowest priority
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= pNum; i++) begin
      idx = PtrBit'((int'(ptr_i) + i) % pNum);
      if (!found && reqVec_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/usi_master_arbiter.sv
// Round-robin owner of the USI master port: grants one master at a time and
// sequences a single write or read (with timeout) per grant.
module usi_master_arbiter
  import usi_pkg::*;
#(
  parameter int pMasterNum  = 4,
  parameter int pBusDataBit = USI_DATA_BIT,
  parameter int pBusAdrsBit = USI_ADRS_MSB,
  parameter int pTimeout    = 255
) (
  input  logic                                  iUsiClk,
  input  logic                                  iUsiRst,
  input  logic [pMasterNum-1:0]                 iMReq,
  input  logic [pMasterNum-1:0]                 iMWCke,
  input  logic [pMasterNum*(pBusAdrsBit+1)-1:0] iMAdrs,
  input  logic [pMasterNum*pBusDataBit-1:0]     iMWd,
  output logic [pMasterNum-1:0]                 oMGnt,
  output logic [pMasterNum-1:0]                 oMAck,
  output logic                                  oMErr,
  output logic [pBusDataBit-1:0]                oMRd,
  output logic [pBusAdrsBit:0]                  oUsiAdrs,
  output logic [pBusDataBit-1:0]                oUsiWd,
  output logic                                  oUsiWCke,
  output logic                                  oUsiRCke,
  input  logic [pBusDataBit-1:0]                iUsiRd,
  input  logic                                  iUsiVd
);

  localparam int         AdrsBit     = pBusAdrsBit + 1;
  localparam int         PtrBit      = $clog2(pMasterNum);
  localparam logic [7:0] TimeoutLast = 8'(pTimeout - 1);

  usiState_e              state_q;
  logic [PtrBit-1:0]      ptr_q;
  logic [PtrBit-1:0]      owner_q;
  logic [7:0]             timer_q;
  logic [pMasterNum-1:0]  gnt_q;
  logic [pMasterNum-1:0]  ack_q;
  logic                   err_q;
  logic [pBusDataBit-1:0] rd_q;
  logic [AdrsBit-1:0]     usiAdrs_q;
  logic [pBusDataBit-1:0] usiWd_q;
  logic                   usiWCke_q;
  logic                   usiRCke_q;

  logic [pMasterNum-1:0]  winGnt_d;
  logic                   winValid_d;
  logic [AdrsBit-1:0]     winAdrs_d;
  logic [pBusDataBit-1:0] winWd_d;
  logic                   winWr_d;
  logic [PtrBit-1:0]      winIdx_d;

  usi_rr_picker #(
    .pNum(pMasterNum)
  ) uPicker (
    .reqVec_i(iMReq),
    .ptr_i   (ptr_q),
    .gnt_o   (winGnt_d),
    .valid_o (winValid_d)
  );

  // Grant is one-hot, so OR-ing the masked slices selects the winner's payload
  always_comb begin
    winAdrs_d = '0;
    winWd_d   = '0;
    winWr_d   = 1'b0;
    for (int i = 0; i < pMasterNum; i++) begin
      if (winGnt_d[i]) begin
        winAdrs_d = winAdrs_d | iMAdrs[i*AdrsBit +: AdrsBit];
        winWd_d   = winWd_d | iMWd[i*pBusDataBit +: pBusDataBit];
        winWr_d   = winWr_d | iMWCke[i];
      end
    end
  end

  assign winIdx_d = PtrBit'(oneHotIdx(USI_MAX_MASTERS'(winGnt_d)));

  always_ff @(posedge iUsiClk) begin
    if (iUsiRst) begin
      state_q   <= IDLE;
      ptr_q     <= PtrBit'(pMasterNum - 1);
      owner_q   <= '0;
      timer_q   <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      usiAdrs_q <= '0;
      usiWd_q   <= '0;
      usiWCke_q <= 1'b0;
      usiRCke_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (winValid_d) begin
            gnt_q     <= winGnt_d;
            owner_q   <= winIdx_d;
            usiAdrs_q <= winAdrs_d;
            usiWd_q   <= winWd_d;
            usiWCke_q <= winWr_d;
            usiRCke_q <= !winWr_d;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          usiAdrs_q <= '0;
          usiWd_q   <= '0;
          usiWCke_q <= 1'b0;
          usiRCke_q <= 1'b0;
          timer_q   <= '0;
          if (usiWCke_q) begin
            ack_q   <= gnt_q;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (iUsiVd) begin
            rd_q    <= iUsiRd;
            err_q   <= 1'b0;
            ack_q   <= gnt_q;
            state_q <= DONE;
          end else if (timer_q == TimeoutLast) begin
            // Unmapped address: complete with an error so the owner is released
            rd_q    <= '0;
            err_q   <= 1'b1;
            ack_q   <= gnt_q;
            state_q <= DONE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        DONE: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          ptr_q   <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oMGnt    = gnt_q;
  assign oMAck    = ack_q;
  assign oMErr    = err_q;
  assign oMRd     = rd_q;
  assign oUsiAdrs = usiAdrs_q;
  assign oUsiWd   = usiWd_q;
  assign oUsiWCke = usiWCke_q;
  assign oUsiRCke = usiRCke_q;

endmodule

// File: tb/tb_usi_master_arbiter.sv
// Self-checking bench for usi_master_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_usi_master_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic            iUsiClk = 1'b0;
  logic            iUsiRst;
  logic [N-1:0]    iMReq;
  logic [N-1:0]    iMWCke;
  logic [N*AW-1:0] iMAdrs;
  logic [N*DW-1:0] iMWd;
  logic [N-1:0]    oMGnt;
  logic [N-1:0]    oMAck;
  logic            oMErr;
  logic [DW-1:0]   oMRd;
  logic [AW-1:0]   oUsiAdrs;
  logic [DW-1:0]   oUsiWd;
  logic            oUsiWCke;
  logic            oUsiRCke;
  logic [DW-1:0]   iUsiRd;
  logic            iUsiVd;

  int nChecks = 0;
  int nErrors = 0;

  wire [90:0] allOut = {oMGnt, oMAck, oMErr, oMRd, oUsiAdrs, oUsiWd, oUsiWCke, oUsiRCke};

  usi_master_arbiter #(
    .pMasterNum (N),
    .pBusDataBit(DW),
    .pBusAdrsBit(AW - 1),
    .pTimeout   (TO)
  ) dut (
    .iUsiClk (iUsiClk),
    .iUsiRst (iUsiRst),
    .iMReq   (iMReq),
    .iMWCke  (iMWCke),
    .iMAdrs  (iMAdrs),
    .iMWd    (iMWd),
    .oMGnt   (oMGnt),
    .oMAck   (oMAck),
    .oMErr   (oMErr),
    .oMRd    (oMRd),
    .oUsiAdrs(oUsiAdrs),
    .oUsiWd  (oUsiWd),
    .oUsiWCke(oUsiWCke),
    .oUsiRCke(oUsiRCke),
    .iUsiRd  (iUsiRd),
    .iUsiVd  (iUsiVd)
  );

  always #5 iUsiClk = ~iUsiClk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Outputs are sampled and inputs driven on the falling edge
  task automatic tick();
    @(negedge iUsiClk);
  endtask

  task automatic setMaster(input int m, input logic req, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    iMReq[m]            = req;
    iMWCke[m]           = wr;
    iMAdrs[m*AW +: AW]  = a;
    iMWd[m*DW +: DW]    = d;
  endtask

  task automatic test_reset();
    $display("[TB] reset");
    iUsiRst = 1'b1;
    tick(); tick(); tick();
    nChecks++; if (allOut !== '0) begin nErrors++; $display("[TB] FAIL reset_outs: got %h exp 0", allOut); end
  endtask

  task automatic test_single_write();
    $display("[TB] single write");
    iUsiRst = 1'b0;
    setMaster(0, 1'b1, 1'b1, 16'h0104, 32'hA5A50001);
    tick();
    nChecks++; if (oUsiWCke !== 1'b1) begin nErrors++; $display("[TB] FAIL sw_wcke: got %b exp 1", oUsiWCke); end
    nChecks++; if (oUsiRCke !== 1'b0) begin nErrors++; $display("[TB] FAIL sw_rcke: got %b exp 0", oUsiRCke); end
    nChecks++; if (oUsiAdrs !== 16'h0104) begin nErrors++; $display("[TB] FAIL sw_adrs: got %h exp 0104", oUsiAdrs); end
    nChecks++; if (oUsiWd !== 32'hA5A50001) begin nErrors++; $display("[TB] FAIL sw_wd: got %h exp a5a50001", oUsiWd); end
    nChecks++; if (oMGnt !== 4'b0001) begin nErrors++; $display("[TB] FAIL sw_gnt: got %b exp 0001", oMGnt); end
    nChecks++; if (oMAck !== 4'b0000) begin nErrors++; $display("[TB] FAIL sw_early_ack: got %b exp 0000", oMAck); end
    tick();
    nChecks++; if (oMAck !== 4'b0001) begin nErrors++; $display("[TB] FAIL sw_ack: got %b exp 0001", oMAck); end
    nChecks++; if (oMErr !== 1'b0) begin nErrors++; $display("[TB] FAIL sw_err: got %b exp 0", oMErr); end
    nChecks++; if ({oUsiWCke, oUsiAdrs, oUsiWd} !== '0) begin nErrors++; $display("[TB] FAIL sw_bus_idle: got %h exp 0", {oUsiWCke, oUsiAdrs, oUsiWd}); end
    setMaster(0, 1'b0, 1'b0, '0, '0);
    tick();
    nChecks++; if ({oMGnt, oMAck} !== 8'h00) begin nErrors++; $display("[TB] FAIL sw_idle: got %h exp 00", {oMGnt, oMAck}); end
  endtask

  task automatic test_back_to_back();
    int order[5] = '{0, 1, 2, 3, 0};
    int own;
    logic [N-1:0] expGnt;
    $display("[TB] back-to-back writes");
    iUsiRst = 1'b1;
    tick();
    iUsiRst = 1'b0;
    for (int m = 0; m < N; m++) setMaster(m, 1'b1, 1'b1, 16'(16'h0100 + m), 32'(32'h1000 + m));
    for (int c = 1; c <= 14; c++) begin
      tick();
      own    = order[(c - 1) / 3];
      expGnt = (c % 3 == 0) ? '0 : N'(1 << own);
      nChecks++; if (oMGnt !== expGnt) begin nErrors++; $display("[TB] FAIL b2b_gnt c=%0d: got %b exp %b", c, oMGnt, expGnt); end
      if (c % 3 == 1) begin
        nChecks++; if (oUsiAdrs !== 16'(16'h0100 + own)) begin nErrors++; $display("[TB] FAIL b2b_adrs c=%0d: got %h exp %h", c, oUsiAdrs, 16'(16'h0100 + own)); end
      end
      if (c % 3 == 2) begin
        nChecks++; if (oMAck !== expGnt) begin nErrors++; $display("[TB] FAIL b2b_ack c=%0d: got %b exp %b", c, oMAck, expGnt); end
        if (own != 0 || c == 14) setMaster(own, 1'b0, 1'b0, '0, '0);
      end else begin
        nChecks++; if (oMAck !== '0) begin nErrors++; $display("[TB] FAIL b2b_noack c=%0d: got %b exp 0000", c, oMAck); end
      end
    end
    tick();
  endtask

  task automatic test_read_valid();
    $display("[TB] read with valid");
    setMaster(2, 1'b1, 1'b0, 16'h0200, 32'h0);
    tick();
    nChecks++; if ({oUsiRCke, oUsiWCke} !== 2'b10) begin nErrors++; $display("[TB] FAIL rd_strobes: got %b exp 10", {oUsiRCke, oUsiWCke}); end
    nChecks++; if (oUsiAdrs !== 16'h0200) begin nErrors++; $display("[TB] FAIL rd_adrs: got %h exp 0200", oUsiAdrs); end
    nChecks++; if (oMGnt !== 4'b0100) begin nErrors++; $display("[TB] FAIL rd_gnt: got %b exp 0100", oMGnt); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      nChecks++; if (oMAck !== '0) begin nErrors++; $display("[TB] FAIL rd_noack c=%0d: got %b exp 0000", c, oMAck); end
    end
    iUsiVd = 1'b1; iUsiRd = 32'h12345678;
    tick();
    iUsiVd = 1'b0; iUsiRd = 32'h0;
    nChecks++; if (oMAck !== 4'b0100) begin nErrors++; $display("[TB] FAIL rd_ack: got %b exp 0100", oMAck); end
    nChecks++; if (oMRd !== 32'h12345678) begin nErrors++; $display("[TB] FAIL rd_data: got %h exp 12345678", oMRd); end
    nChecks++; if (oMErr !== 1'b0) begin nErrors++; $display("[TB] FAIL rd_err: got %b exp 0", oMErr); end
    setMaster(2, 1'b0, 1'b0, '0, '0);
    tick();
    nChecks++; if (oMRd !== 32'h12345678) begin nErrors++; $display("[TB] FAIL rd_hold: got %h exp 12345678", oMRd); end
  endtask

  task automatic test_timeout();
    $display("[TB] read timeout");
    setMaster(1, 1'b1, 1'b0, 16'h7F00, 32'h0);
    tick();
    nChecks++; if (oUsiRCke !== 1'b1) begin nErrors++; $display("[TB] FAIL to_rcke: got %b exp 1", oUsiRCke); end
    for (int c = 2; c < 2 + TO; c++) begin
      tick();
      nChecks++; if (oMAck !== '0) begin nErrors++; $display("[TB] FAIL to_noack c=%0d: got %b exp 0000", c, oMAck); end
    end
    tick();
    nChecks++; if (oMAck !== 4'b0010) begin nErrors++; $display("[TB] FAIL to_ack: got %b exp 0010", oMAck); end
    nChecks++; if (oMErr !== 1'b1) begin nErrors++; $display("[TB] FAIL to_err: got %b exp 1", oMErr); end
    nChecks++; if (oMRd !== 32'h0) begin nErrors++; $display("[TB] FAIL to_rd: got %h exp 0", oMRd); end
    setMaster(1, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset during read wait");
    setMaster(0, 1'b1, 1'b1, 16'h0110, 32'h0);
    tick(); tick();
    setMaster(0, 1'b0, 1'b0, '0, '0);
    tick();
    setMaster(3, 1'b1, 1'b0, 16'h0300, 32'h0);
    tick(); tick(); tick();
    iUsiRst = 1'b1;
    tick();
    nChecks++; if (allOut !== '0) begin nErrors++; $display("[TB] FAIL rm_outs: got %h exp 0", allOut); end
    iUsiRst = 1'b0;
    setMaster(3, 1'b0, 1'b0, '0, '0);
    setMaster(0, 1'b1, 1'b1, 16'h0120, 32'h0);
    setMaster(1, 1'b1, 1'b1, 16'h0121, 32'h0);
    tick();
    nChecks++; if (oMGnt !== 4'b0001) begin nErrors++; $display("[TB] FAIL rm_first_gnt: got %b exp 0001", oMGnt); end
    tick();
    nChecks++; if (oMAck !== 4'b0001) begin nErrors++; $display("[TB] FAIL rm_first_ack: got %b exp 0001", oMAck); end
    setMaster(0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    nChecks++; if (oMGnt !== 4'b0010) begin nErrors++; $display("[TB] FAIL rm_second_gnt: got %b exp 0010", oMGnt); end
    tick();
    setMaster(1, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_vd_in_issue();
    $display("[TB] valid during issue ignored");
    setMaster(1, 1'b1, 1'b0, 16'h0400, 32'h0);
    tick();
    iUsiVd = 1'b1; iUsiRd = 32'hDEADBEEF;
    tick();
    iUsiVd = 1'b0; iUsiRd = 32'h0;
    nChecks++; if (oMAck !== '0) begin nErrors++; $display("[TB] FAIL vi_early_ack: got %b exp 0000", oMAck); end
    tick();
    nChecks++; if (oMAck !== '0) begin nErrors++; $display("[TB] FAIL vi_noack: got %b exp 0000", oMAck); end
    iUsiVd = 1'b1; iUsiRd = 32'hCAFEF00D;
    tick();
    iUsiVd = 1'b0; iUsiRd = 32'h0;
    nChecks++; if (oMAck !== 4'b0010) begin nErrors++; $display("[TB] FAIL vi_ack: got %b exp 0010", oMAck); end
    nChecks++; if (oMRd !== 32'hCAFEF00D) begin nErrors++; $display("[TB] FAIL vi_data: got %h exp cafef00d", oMRd); end
    setMaster(1, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  // Transaction-level model: pending masters, last owner, and fixed latencies
  task automatic test_random();
    bit            pending[N];
    bit            pWr[N];
    logic [AW-1:0] pAdrs[N];
    logic [DW-1:0] pWd[N];
    int            ptr, w, d, expAck;
    bit            spurious, any;
    logic [DW-1:0] rdData, expRd;
    logic          expErr;
    logic [N-1:0]  expGnt;
    $display("[TB] randomized transactions");
    for (int m = 0; m < N; m++) pending[m] = 1'b0;
    iMReq   = '0;
    iUsiRst = 1'b1;
    tick();
    iUsiRst = 1'b0;
    ptr = N - 1;
    for (int t = 0; t < 40; t++) begin
      any = 1'b0;
      for (int m = 0; m < N; m++) begin
        if (!pending[m] && $urandom_range(0, 1) == 1) begin
          pending[m] = 1'b1;
          pWr[m]     = 1'($urandom_range(0, 1));
          pAdrs[m]   = 16'($urandom);
          pWd[m]     = $urandom;
        end
        any = any | pending[m];
      end
      if (!any) begin
        w = $urandom_range(0, N - 1);
        pending[w] = 1'b1; pWr[w] = 1'b1; pAdrs[w] = 16'($urandom); pWd[w] = $urandom;
      end
      for (int m = 0; m < N; m++) setMaster(m, pending[m], pWr[m], pAdrs[m], pWd[m]);
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && pending[(ptr + k) % N]) w = (ptr + k) % N;
      expGnt   = N'(1 << w);
      d        = $urandom_range(1, TO + 2);
      spurious = 1'($urandom_range(0, 1));
      rdData   = $urandom;
      if (pWr[w]) begin expAck = 2; expErr = 1'b0; expRd = '0; end
      else if (d <= TO) begin expAck = d + 2; expErr = 1'b0; expRd = rdData; end
      else begin expAck = TO + 2; expErr = 1'b1; expRd = '0; end
      tick();
      nChecks++; if (oMGnt !== expGnt) begin nErrors++; $display("[TB] FAIL rnd_gnt t=%0d: got %b exp %b", t, oMGnt, expGnt); end
      nChecks++; if ({oUsiWCke, oUsiRCke} !== {pWr[w], !pWr[w]}) begin nErrors++; $display("[TB] FAIL rnd_strobe t=%0d: got %b exp %b", t, {oUsiWCke, oUsiRCke}, {pWr[w], !pWr[w]}); end
      nChecks++; if ({oUsiAdrs, oUsiWd} !== {pAdrs[w], pWd[w]}) begin nErrors++; $display("[TB] FAIL rnd_bus t=%0d: got %h exp %h", t, {oUsiAdrs, oUsiWd}, {pAdrs[w], pWd[w]}); end
      iUsiVd = spurious & !pWr[w];
      iUsiRd = $urandom;
      if ($urandom_range(0, 3) == 0) iMReq[w] = 1'b0;
      for (int c = 2; c <= expAck; c++) begin
        tick();
        if (c < expAck) begin
          nChecks++; if (oMAck !== '0) begin nErrors++; $display("[TB] FAIL rnd_noack t=%0d c=%0d: got %b exp 0000", t, c, oMAck); end
        end else begin
          nChecks++; if (oMAck !== expGnt) begin nErrors++; $display("[TB] FAIL rnd_ack t=%0d: got %b exp %b", t, oMAck, expGnt); end
          nChecks++; if (oMErr !== expErr) begin nErrors++; $display("[TB] FAIL rnd_err t=%0d: got %b exp %b", t, oMErr, expErr); end
          if (!pWr[w]) begin
            nChecks++; if (oMRd !== expRd) begin nErrors++; $display("[TB] FAIL rnd_rd t=%0d: got %h exp %h", t, oMRd, expRd); end
          end
        end
        iUsiVd = !pWr[w] && d <= TO && c == 1 + d;
        iUsiRd = iUsiVd ? rdData : $urandom;
      end
      pending[w] = 1'b0;
      iMReq[w]   = 1'b0;
      ptr        = w;
      tick();
      nChecks++; if ({oMGnt, oMAck} !== '0) begin nErrors++; $display("[TB] FAIL rnd_idle t=%0d: got %h exp 00", t, {oMGnt, oMAck}); end
    end
    iMReq  = '0;
    iUsiVd = 1'b0;
  endtask

  initial begin
    iUsiRst = 1'b1;
    iMReq   = '0;
    iMWCke  = '0;
    iMAdrs  = '0;
    iMWd    = '0;
    iUsiRd  = '0;
    iUsiVd  = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_valid();
    test_timeout();
    test_reset_mid();
    test_vd_in_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/usi_master_arbiter.md
Name: usi_master_arbiter

Overview:
Round-robin arbiter that shares the single UltraSimpleInterface (USI) bus between up to pMasterNum masters: the MCB, and in future VDMA, ADMA and PSRAM control engines. It sits between the masters and the USI master port. For each granted master it sequences exactly one transaction (write or read) and returns read data, completion and error status. It also enforces a read timeout, so an unmapped address cannot hang the bus.

Parameters:
pMasterNum, 4, number of requesting masters (2..8)
pBusDataBit, 32, bus data width in bits
pBusAdrsBit, 15, bus address MSB index (address width = pBusAdrsBit+1)
pTimeout, 255, maximum cycles spent waiting for read valid (1..255, 8-bit counter)

Ports:
iUsiClk  in  1  bus clock; single clock domain
iUsiRst  in  1  synchronous, active-high reset
iMReq  in  pMasterNum  per-master request; held with payload until oMAck
iMWCke  in  pMasterNum  per-master transaction type: 1 = write, 0 = read
iMAdrs  in  pMasterNum*(pBusAdrsBit+1)  packed addresses; master i occupies slice i
iMWd  in  pMasterNum*pBusDataBit  packed write data
oMGnt  out  pMasterNum  one-hot current owner
oMAck  out  pMasterNum  one-cycle completion pulse to owner
oMErr  out  1  valid with oMAck; 1 = read timeout
oMRd  out  pBusDataBit  read data, valid with oMAck
oUsiAdrs  out  pBusAdrsBit+1  bus address
oUsiWd  out  pBusDataBit  bus write data
oUsiWCke  out  1  one-cycle write strobe
oUsiRCke  out  1  one-cycle read strobe
iUsiRd  in  pBusDataBit  muxed slave read data
iUsiVd  in  1  OR of slave valid flags

Behaviour:
- All outputs are registered. Reset values: state IDLE, all outputs 0, rotate pointer = pMasterNum-1, so master 0 has highest priority after reset.
- IDLE:
  - If any iMReq bit is set, pick the winner by round-robin, searching from pointer+1 and wrapping.
  - Latch the winner's adrs, wd and WCke. Set oMGnt to the winner. Next state ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive oUsiAdrs and oUsiWd.
  - oUsiWCke = latched WCke; oUsiRCke = not latched WCke.
  - Next state: DONE for a write; WAIT_RD for a read, with the timer cleared.
- WAIT_RD:
  - iUsiVd=1: capture iUsiRd, oMErr=0, go to DONE.
  - iUsiVd=0: increment the timer. When timer == pTimeout-1, set oMRd=0, oMErr=1, go to DONE. The total wait is therefore exactly pTimeout cycles.
  - iUsiVd is sampled only in WAIT_RD; valid asserted during ISSUE is ignored.
- DONE (1 cycle):
  - oMAck[owner]=1; oMRd and oMErr are held.
  - Pointer = owner. Next state IDLE. oMGnt clears on entry to IDLE.
- Strobes, address and data return to 0 outside ISSUE; oMRd and oMErr hold until the next DONE.
- Latency:
  - Write: request seen in cycle 0 → strobe in cycle 1 → ack in cycle 2.
  - Read: ack arrives 1 cycle after the Vd cycle (minimum ack in cycle 3).
  - Back-to-back writes complete at most every 3 cycles.
- Request withdrawn after grant is ignored: the transaction completes and the ack is still pulsed.
- A master holding iMReq in the cycle after oMAck is treated as a new request.
- Simultaneous requests: only one master is granted per IDLE pass; the others wait, with no starvation (each waits at most pMasterNum-1 transactions).
- Reset mid-transaction: the next cycle is IDLE with all outputs 0. No ack is issued and the pointer is reset.

Decomposition:
- Package usi_pkg holds:
  - bus width constants (32 data, 15 address MSB index)
  - block address map constants (GPIO 0x01 … PSRAM 0x09)
  - state encoding (IDLE, ISSUE, WAIT_RD, DONE)
- One combinational sub-module, usi_rr_picker: takes request vector and pointer, returns one-hot grant and a valid flag. It is reused later by the ADMA/VDMA schedulers.

Test Plan:
- Master 0 writes adrs 0x0104, wd 0xA5A50001 → cycle 1: oUsiWCke=1, oUsiAdrs=0x0104; cycle 2: oMAck=4'b0001, oMErr=0.
- All 4 masters request writes at cycle 0 after reset → grants in order 0,1,2,3; acks at cycles 2, 5, 8, 11. Master 0 then re-requests and wins only after master 3.
- Master 2 reads adrs 0x0200; slave drives iUsiVd=1 with 0x12345678 three cycles after oUsiRCke → oMAck=4'b0100, oMRd=0x12345678, oMErr=0.
- Read of unmapped adrs 0x7F00 with pTimeout=8 and no Vd → ack 8 cycles after entering WAIT_RD, oMErr=1, oMRd=0.
- iUsiRst pulsed during WAIT_RD → next cycle all outputs 0, no ack. After release with masters 1 and 0 both requesting, master 0 is granted first.
- iUsiVd=1 during ISSUE and again 2 cycles later with 0xCAFEF00D → only the second is captured; oMRd=0xCAFEF00D.
